ece453_led_sequencer: RTL
=========================

# ece453_led_sequencer

Parametrised LED pattern sequencer for the lab board's LED bank. It generalises the fixed 4-LED walking FSM to NUM_LEDS outputs and adds a programmable step-rate prescaler, three pattern modes (walk, bounce, fill), and a button-controlled pause/resume. It sits between the board push-button/switch inputs and the LED pins, and exposes its state encoding for bench and debug observation.

## Interface

- NUM_LEDS, default 8: LED count; legal range 2..32.
- PRESCALE_W, default 16: width of step_div.
- DEBOUNCE_CYCLES, default 4: stable-sample count for the button; used only when ECE453_LED_SEQ_DEBOUNCE_EN is defined.

Ports:

- clk  in  1  system clock. One clock domain.
- reset  in  1  synchronous, active-high reset.
- fsm_enable  in  1  level; high runs the sequencer, low forces START.
- button  in  1  raw asynchronous push-button; a rising edge toggles pause.
- direction  in  1  0 = toward LSB-to-MSB (position increments), 1 = reverse.
- mode  in  2  0 = walk, 1 = bounce, 2 = fill, 3 = walk.
- step_div  in  PRESCALE_W  step period minus 1, in clk cycles.
- led_out  out  NUM_LEDS  LED drive, active-high.
- current_state  out  3  START = 3'd0, RUN = 3'd1, PAUSED = 3'd2.
- position  out  $clog2(NUM_LEDS)  current step index.
- wrap  out  1  one-cycle pulse on pattern wrap or reversal.

## Operation

- Reset values: current_state = START, led_out = 0, position = 0, wrap = 0, prescaler = 0, bounce direction = 0, button synchroniser flops = 0.
- START: led_out = 0 and prescaler held at 0.
  - fsm_enable = 1 → RUN at the next edge.
  - On that transition, position loads 0 if direction = 0, else NUM_LEDS-1, and bounce direction loads direction.
- RUN:
  - The prescaler counts 0..step_div. On the cycle it equals step_div, a step occurs and the prescaler returns to 0.
  - step_div is sampled live. If step_div is lowered below the current count, a step occurs on the next cycle and the count restarts.
- PAUSED: prescaler, position and bounce direction hold; led_out holds its pattern.
- A button edge toggles RUN↔PAUSED. Button edges in START are ignored.
- fsm_enable = 0 in RUN or PAUSED → START at the next edge; led_out = 0 from then.
- Priority, highest first: reset, fsm_enable low, button edge, step. When a button edge and a step coincide, the state toggles and no step occurs.
- Walk mode:
  - led_out is one-hot at position.
  - A step moves position ±1 per direction, sampled at each step.
  - Stepping NUM_LEDS-1→0 or 0→NUM_LEDS-1 pulses wrap.
- Bounce mode:
  - led_out is one-hot at position. The live direction input is ignored; the internal bounce direction is used.
  - At an end (position = NUM_LEDS-1 moving up, or 0 moving down), the step reverses the bounce direction and moves one position back, e.g. 7→6. That step pulses wrap.
- Fill mode:
  - direction = 0: led_out bits [position:0] are set.
  - direction = 1: bits [NUM_LEDS-1:position] are set.
  - A step past full returns to the single-LED start and pulses wrap.
- led_out is a combinational decode of current_state, mode, position and direction. A change of mode or direction is visible in the same cycle.
- A mode change keeps position; only the decode changes.

## Timing

- fsm_enable sampled high at edge k → current_state = RUN and the first pattern appear after edge k.
- First step occurs step_div+1 cycles after entering RUN. Subsequent steps occur every step_div+1 cycles. step_div = 0 gives one step per cycle.
- Button path: 2-flop synchroniser, then an edge register. With button raw-high sampled at edge k, the state toggles at edge k+2.
- wrap is high for exactly the one cycle following the wrapping step edge.
- Reset asserted mid-run is honoured at the next edge, regardless of any other inputs.

## Configuration

- ECE453_LED_SEQ_DEBOUNCE_EN
  - Defined: after the synchroniser, the synchronised button must hold a new level for DEBOUNCE_CYCLES consecutive cycles before the debounced level updates. The edge detect uses the debounced level, adding DEBOUNCE_CYCLES cycles of latency. Pulses shorter than that are ignored.
  - Undefined: synchroniser plus edge detect only; every synchronised rising edge toggles the state.

## Test plan

- Reset: hold reset 2 cycles with fsm_enable = 1 → current_state = 0, led_out = 8'h00, wrap = 0. Release reset → RUN on the next edge.
- Walk (NUM_LEDS = 8, step_div = 3, direction = 0, mode = 0): led_out runs 01, 02, …, 80, each for 4 cycles. After 32 cycles led_out = 01 with wrap high for 1 cycle. Repeat with direction = 1: sequence 80, 40, …, 01.
- Bounce (step_div = 0, mode = 1): led_out runs 01, 02, …, 80, 40, …, 01, 02. wrap pulses on the 80→40 and 01→02 steps. Toggling direction mid-run has no effect.
- Fill (step_div = 0, mode = 2, direction = 1): led_out runs 80, C0, E0, …, FF, then 80 with a wrap pulse.
- Pause: button high 1 cycle in RUN (macro undefined) → current_state = 2 at edge k+2 and led_out frozen for 20 cycles. Second pulse → RUN, and stepping resumes from the held prescaler count. Drop fsm_enable → state 0, led_out 00. A button edge coinciding with a step → no advance.
- Debounce (macro defined, DEBOUNCE_CYCLES = 4): a 2-cycle button glitch → no state change. Button held 6 cycles → exactly one toggle.

Source files
------------

// File: rtl/ece453_led_sequencer.sv
// rtl/ece453_led_sequencer.sv - parametrised LED walk/bounce/fill sequencer with step prescaler and pause button
// Optional button debounce stage is enabled by defining ECE453_LED_SEQ_DEBOUNCE_EN.
module ece453_led_sequencer #(
    parameter int NUM_LEDS        = 8,
    parameter int PRESCALE_W      = 16,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        fsm_enable,
    input  logic                        button,
    input  logic                        direction,
    input  logic [1:0]                  mode,
    input  logic [PRESCALE_W-1:0]       step_div,
    output logic [NUM_LEDS-1:0]         led_out,
    output logic [2:0]                  current_state,
    output logic [$clog2(NUM_LEDS)-1:0] position,
    output logic                        wrap
);

    localparam int               POS_W       = $clog2(NUM_LEDS);
    localparam logic [POS_W-1:0] POS_LAST    = POS_W'(NUM_LEDS - 1);
    localparam logic [1:0]       MODE_BOUNCE = 2'd1;
    localparam logic [1:0]       MODE_FILL   = 2'd2;

    typedef enum logic [2:0] {
        START  = 3'd0,
        RUN    = 3'd1,
        PAUSED = 3'd2
    } state_t;

    if (NUM_LEDS < 2 || NUM_LEDS > 32) begin : g_bad_num_leds
        $error("ece453_led_sequencer: NUM_LEDS must be in 2..32");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("ece453_led_sequencer: DEBOUNCE_CYCLES must be at least 1");
    end

    state_t                state;
    state_t                next_state;
    logic [PRESCALE_W-1:0] prescaler;
    logic                  bounce_dir;

    logic                  btn_meta;
    logic                  btn_sync;
    logic                  btn_level;
    logic                  btn_prev;
    logic                  btn_edge;

    logic [POS_W-1:0]      step_pos;
    logic                  step_bdir;
    logic                  step_wrap;
    logic [31:0]           pos_ext;

    // Two-flop synchroniser for the raw push-button.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            btn_meta <= button;
            btn_sync <= btn_meta;
        end
    end

`ifdef ECE453_LED_SEQ_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [DB_W-1:0] db_count;
    logic            db_level;

    always_ff @(posedge clk) begin
        if (reset) begin
            db_count <= '0;
            db_level <= 1'b0;
        end else if (btn_sync == db_level) begin
            db_count <= '0;
        end else if (db_count == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            db_level <= btn_sync;
            db_count <= '0;
        end else begin
            db_count <= db_count + DB_W'(1);
        end
    end

    assign btn_level = db_level;
`else
    assign btn_level = btn_sync;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_prev <= 1'b0;
        end else begin
            btn_prev <= btn_level;
        end
    end

    assign btn_edge = btn_level & ~btn_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= START;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            START: begin
                if (fsm_enable) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (!fsm_enable) begin
                    next_state = START;
                end else if (btn_edge) begin
                    next_state = PAUSED;
                end
            end
            PAUSED: begin
                if (!fsm_enable) begin
                    next_state = START;
                end else if (btn_edge) begin
                    next_state = RUN;
                end
            end
            default: next_state = START;
        endcase
    end

    // Where the pattern goes on the next step; walk and fill share the same stepping.
    always_comb begin
        step_pos  = position;
        step_bdir = bounce_dir;
        step_wrap = 1'b0;
        if (mode == MODE_BOUNCE) begin
            if (!bounce_dir) begin
                if (position == POS_LAST) begin
                    step_pos  = position - POS_W'(1);
                    step_bdir = 1'b1;
                    step_wrap = 1'b1;
                end else begin
                    step_pos = position + POS_W'(1);
                end
            end else begin
                if (position == '0) begin
                    step_pos  = POS_W'(1);
                    step_bdir = 1'b0;
                    step_wrap = 1'b1;
                end else begin
                    step_pos = position - POS_W'(1);
                end
            end
        end else begin
            if (!direction) begin
                if (position == POS_LAST) begin
                    step_pos  = '0;
                    step_wrap = 1'b1;
                end else begin
                    step_pos = position + POS_W'(1);
                end
            end else begin
                if (position == '0) begin
                    step_pos  = POS_LAST;
                    step_wrap = 1'b1;
                end else begin
                    step_pos = position - POS_W'(1);
                end
            end
        end
    end

    // A button edge or a pending drop to START wins over a step, so the prescaler just holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler  <= '0;
            position   <= '0;
            bounce_dir <= 1'b0;
            wrap       <= 1'b0;
        end else begin
            wrap <= 1'b0;
            case (state)
                START: begin
                    prescaler <= '0;
                    if (fsm_enable) begin
                        position   <= direction ? POS_LAST : '0;
                        bounce_dir <= direction;
                    end
                end
                RUN: begin
                    if (fsm_enable && !btn_edge) begin
                        if (prescaler >= step_div) begin
                            prescaler  <= '0;
                            position   <= step_pos;
                            bounce_dir <= step_bdir;
                            wrap       <= step_wrap;
                        end else begin
                            prescaler <= prescaler + PRESCALE_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign pos_ext = 32'(position);

    always_comb begin
        current_state = state;
        led_out       = '0;
        if (state != START) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (mode == MODE_FILL) begin
                    led_out[i] = direction ? (32'(i) >= pos_ext) : (32'(i) <= pos_ext);
                end else begin
                    led_out[i] = (32'(i) == pos_ext);
                end
            end
        end
    end

endmodule
